// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the Bat Amateur processor: a two-step fetch
// followed by a 1-3 step execute, with strobes decoded from state, opcode and flags.
module control_sequencer #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 RUN,
    input  logic [BUS_WIDTH-1:0] INSTRUCTION,
    input  logic                 CARRY_FLAG,
    input  logic                 ZERO_FLAG,
    output logic                 PC_COUNT,
    output logic                 PC_LOAD,
    output logic                 PC_ENABLE,
    output logic                 MAR_LOAD,
    output logic                 RAM_LOAD,
    output logic                 RAM_ENABLE,
    output logic                 IR_LOAD,
    output logic                 IR_ENABLE,
    output logic                 A_LOAD,
    output logic                 A_ENABLE,
    output logic                 B_LOAD,
    output logic                 ALU_ENABLE,
    output logic                 ALU_SUB,
    output logic                 FLAG_LOAD,
    output logic                 OUT_LOAD,
    output logic [2:0]           STEP,
    output logic                 HALTED
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        E2   = 3'd3,
        E3   = 3'd4,
        E4   = 3'd5,
        HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions in the packed strobe vector, MSB first as the ports are listed.
    localparam logic [14:0] S_PC_COUNT   = 15'h4000;
    localparam logic [14:0] S_PC_LOAD    = 15'h2000;
    localparam logic [14:0] S_PC_ENABLE  = 15'h1000;
    localparam logic [14:0] S_MAR_LOAD   = 15'h0800;
    localparam logic [14:0] S_RAM_LOAD   = 15'h0400;
    localparam logic [14:0] S_RAM_ENABLE = 15'h0200;
    localparam logic [14:0] S_IR_LOAD    = 15'h0100;
    localparam logic [14:0] S_IR_ENABLE  = 15'h0080;
    localparam logic [14:0] S_A_LOAD     = 15'h0040;
    localparam logic [14:0] S_A_ENABLE   = 15'h0020;
    localparam logic [14:0] S_B_LOAD     = 15'h0010;
    localparam logic [14:0] S_ALU_ENABLE = 15'h0008;
    localparam logic [14:0] S_ALU_SUB    = 15'h0004;
    localparam logic [14:0] S_FLAG_LOAD  = 15'h0002;
    localparam logic [14:0] S_OUT_LOAD   = 15'h0001;

    // Number of execute steps after fetch; opcodes A-E fall through as NOP.
    function automatic logic [1:0] exec_steps(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                                 exec_steps = 2'd2;
            OP_ADD, OP_SUB:                                 exec_steps = 2'd3;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   exec_steps = 2'd1;
            default:                                        exec_steps = 2'd0;
        endcase
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  opcode_s;
    logic [1:0]  len_s;
    logic [14:0] strobe_s;
    logic        operand_unused_s;

    assign opcode_s         = INSTRUCTION[BUS_WIDTH-1 -: 4];
    assign operand_unused_s = ^INSTRUCTION[BUS_WIDTH-5:0];
    assign len_s            = exec_steps(opcode_s);

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing; RUN low freezes everything except the absorbing HALT.
    always_comb begin
        next_state_s = state_r;
        if (RUN) begin
            case (state_r)
                IDLE:    next_state_s = F0;
                F0:      next_state_s = F1;
                F1:      next_state_s = (len_s == 2'd0) ? F0 : E2;
                E2: begin
                    if (opcode_s == OP_HLT) begin
                        next_state_s = HALT;
                    end else if (len_s > 2'd1) begin
                        next_state_s = E3;
                    end else begin
                        next_state_s = F0;
                    end
                end
                E3:      next_state_s = (len_s > 2'd2) ? E4 : F0;
                E4:      next_state_s = F0;
                HALT:    next_state_s = HALT;
                default: next_state_s = IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Microcode decode: strobes from state, opcode and flags.
    always_comb begin
        strobe_s = 15'h0000;
        if (RUN) begin
            case (state_r)
                F0: strobe_s = S_PC_ENABLE | S_MAR_LOAD;
                F1: strobe_s = S_RAM_ENABLE | S_IR_LOAD | S_PC_COUNT;
                E2: begin
                    case (opcode_s)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: strobe_s = S_IR_ENABLE | S_MAR_LOAD;
                        OP_LDI:  strobe_s = S_IR_ENABLE | S_A_LOAD;
                        OP_JMP:  strobe_s = S_IR_ENABLE | S_PC_LOAD;
                        OP_JC:   strobe_s = CARRY_FLAG ? (S_IR_ENABLE | S_PC_LOAD) : 15'h0000;
                        OP_JZ:   strobe_s = ZERO_FLAG ? (S_IR_ENABLE | S_PC_LOAD) : 15'h0000;
                        OP_OUT:  strobe_s = S_A_ENABLE | S_OUT_LOAD;
                        default: strobe_s = 15'h0000;
                    endcase
                end
                E3: begin
                    case (opcode_s)
                        OP_LDA:         strobe_s = S_RAM_ENABLE | S_A_LOAD;
                        OP_ADD, OP_SUB: strobe_s = S_RAM_ENABLE | S_B_LOAD;
                        OP_STA:         strobe_s = S_A_ENABLE | S_RAM_LOAD;
                        default:        strobe_s = 15'h0000;
                    endcase
                end
                E4: begin
                    case (opcode_s)
                        OP_ADD:  strobe_s = S_ALU_ENABLE | S_A_LOAD | S_FLAG_LOAD;
                        OP_SUB:  strobe_s = S_ALU_ENABLE | S_A_LOAD | S_FLAG_LOAD | S_ALU_SUB;
                        default: strobe_s = 15'h0000;
                    endcase
                end
                default: strobe_s = 15'h0000;
            endcase
        end else begin
            strobe_s = 15'h0000;
        end
    end

    assign {PC_COUNT, PC_LOAD, PC_ENABLE, MAR_LOAD, RAM_LOAD, RAM_ENABLE, IR_LOAD,
            IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE, ALU_SUB, FLAG_LOAD,
            OUT_LOAD} = strobe_s;

    assign STEP   = state_r;
    assign HALTED = (state_r == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random opcodes,
// checked against a per-opcode micro-step list built from the instruction table.
module tb_control_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET, RUN, CARRY_FLAG, ZERO_FLAG;
    logic [15:0] INSTRUCTION;
    logic        PC_COUNT, PC_LOAD, PC_ENABLE, MAR_LOAD, RAM_LOAD, RAM_ENABLE;
    logic        IR_LOAD, IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE;
    logic        ALU_SUB, FLAG_LOAD, OUT_LOAD, HALTED;
    logic [2:0]  STEP;
    logic [14:0] obs_mask;
    logic [4:0]  obs_en;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] M_PC_COUNT   = 15'h4000;
    localparam logic [14:0] M_PC_LOAD    = 15'h2000;
    localparam logic [14:0] M_PC_ENABLE  = 15'h1000;
    localparam logic [14:0] M_MAR_LOAD   = 15'h0800;
    localparam logic [14:0] M_RAM_LOAD   = 15'h0400;
    localparam logic [14:0] M_RAM_ENABLE = 15'h0200;
    localparam logic [14:0] M_IR_LOAD    = 15'h0100;
    localparam logic [14:0] M_IR_ENABLE  = 15'h0080;
    localparam logic [14:0] M_A_LOAD     = 15'h0040;
    localparam logic [14:0] M_A_ENABLE   = 15'h0020;
    localparam logic [14:0] M_B_LOAD     = 15'h0010;
    localparam logic [14:0] M_ALU_ENABLE = 15'h0008;
    localparam logic [14:0] M_ALU_SUB    = 15'h0004;
    localparam logic [14:0] M_FLAG_LOAD  = 15'h0002;
    localparam logic [14:0] M_OUT_LOAD   = 15'h0001;

    typedef struct {
        logic [2:0]  step;
        logic [14:0] mask;
    } ustep_t;

    control_sequencer #(.BUS_WIDTH(16)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .RUN(RUN), .INSTRUCTION(INSTRUCTION),
        .CARRY_FLAG(CARRY_FLAG), .ZERO_FLAG(ZERO_FLAG),
        .PC_COUNT(PC_COUNT), .PC_LOAD(PC_LOAD), .PC_ENABLE(PC_ENABLE),
        .MAR_LOAD(MAR_LOAD), .RAM_LOAD(RAM_LOAD), .RAM_ENABLE(RAM_ENABLE),
        .IR_LOAD(IR_LOAD), .IR_ENABLE(IR_ENABLE), .A_LOAD(A_LOAD),
        .A_ENABLE(A_ENABLE), .B_LOAD(B_LOAD), .ALU_ENABLE(ALU_ENABLE),
        .ALU_SUB(ALU_SUB), .FLAG_LOAD(FLAG_LOAD), .OUT_LOAD(OUT_LOAD),
        .STEP(STEP), .HALTED(HALTED)
    );

    always #5 CLOCK = ~CLOCK;

    assign obs_mask = {PC_COUNT, PC_LOAD, PC_ENABLE, MAR_LOAD, RAM_LOAD, RAM_ENABLE,
                       IR_LOAD, IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE,
                       ALU_SUB, FLAG_LOAD, OUT_LOAD};
    assign obs_en   = {PC_ENABLE, RAM_ENABLE, IR_ENABLE, A_ENABLE, ALU_ENABLE};

    task automatic go_edge();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] s, input logic [14:0] m, input logic h);
        checks++;
        assert ({STEP, HALTED, obs_mask} === {s, h, m}) else begin
            errors++;
            $error("FAIL %s: observed step=%0d halted=%0b strobes=%h, expected step=%0d halted=%0b strobes=%h",
                   tag, STEP, HALTED, obs_mask, s, h, m);
        end
        checks++;
        assert ($countones(obs_en) <= 1) else begin
            errors++;
            $error("FAIL %s_one_enable: observed enables=%b, expected at most one set", tag, obs_en);
        end
    endtask

    // Runs one instruction starting in F0; returns early after checking entry abort_idx.
    task automatic run_instr(input logic [15:0] instr, input logic carry, input logic zero,
                             input bit rand_run, input int hold_idx, input int abort_idx);
        ustep_t q[$];
        logic [3:0] op;
        op = instr[15:12];
        INSTRUCTION = instr;
        CARRY_FLAG  = carry;
        ZERO_FLAG   = zero;
        q.push_back('{3'd1, M_PC_ENABLE | M_MAR_LOAD});
        q.push_back('{3'd2, M_RAM_ENABLE | M_IR_LOAD | M_PC_COUNT});
        case (op)
            4'h1: begin
                q.push_back('{3'd3, M_IR_ENABLE | M_MAR_LOAD});
                q.push_back('{3'd4, M_RAM_ENABLE | M_A_LOAD});
            end
            4'h2, 4'h3: begin
                q.push_back('{3'd3, M_IR_ENABLE | M_MAR_LOAD});
                q.push_back('{3'd4, M_RAM_ENABLE | M_B_LOAD});
                q.push_back('{3'd5, M_ALU_ENABLE | M_A_LOAD | M_FLAG_LOAD |
                                    ((op == 4'h3) ? M_ALU_SUB : 15'h0000)});
            end
            4'h4: begin
                q.push_back('{3'd3, M_IR_ENABLE | M_MAR_LOAD});
                q.push_back('{3'd4, M_A_ENABLE | M_RAM_LOAD});
            end
            4'h5: q.push_back('{3'd3, M_IR_ENABLE | M_A_LOAD});
            4'h6: q.push_back('{3'd3, M_IR_ENABLE | M_PC_LOAD});
            4'h7: q.push_back('{3'd3, carry ? (M_IR_ENABLE | M_PC_LOAD) : 15'h0000});
            4'h8: q.push_back('{3'd3, zero ? (M_IR_ENABLE | M_PC_LOAD) : 15'h0000});
            4'h9: q.push_back('{3'd3, M_A_ENABLE | M_OUT_LOAD});
            4'hF: q.push_back('{3'd3, 15'h0000});
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            int want;
            want = (i == hold_idx) ? 3 : 0;
            if (rand_run && ($urandom_range(0, 3) == 0)) want = $urandom_range(1, 2);
            for (int d = 0; d < want; d++) begin
                RUN = 1'b0;
                #1;
                chk("run_low_hold", q[i].step, 15'h0000, 1'b0);
                go_edge();
            end
            RUN = 1'b1;
            #1;
            chk($sformatf("op%h_step%0d", op, i), q[i].step, q[i].mask, 1'b0);
            if (i == abort_idx) return;
            go_edge();
        end
    endtask

    initial begin
        RESET = 1'b0; RUN = 1'b1; INSTRUCTION = 16'h0000;
        CARRY_FLAG = 1'b0; ZERO_FLAG = 1'b0;
        #12;
        chk("reset_state", 3'd0, 15'h0000, 1'b0);
        go_edge();
        RESET = 1'b1;
        #1;
        chk("idle_after_release", 3'd0, 15'h0000, 1'b0);
        go_edge();

        // NOP loop: 1,2,1,2,...
        for (int k = 0; k < 3; k++) run_instr(16'h0000, 1'b0, 1'b0, 1'b0, -1, -1);
        run_instr(16'h3005, 1'b0, 1'b0, 1'b0, -1, -1);
        run_instr(16'h7010, 1'b1, 1'b0, 1'b0, -1, -1);
        run_instr(16'h7010, 1'b0, 1'b1, 1'b0, -1, -1);
        run_instr(16'h8020, 1'b0, 1'b1, 1'b0, -1, -1);
        run_instr(16'hB123, 1'b1, 1'b1, 1'b0, -1, -1);
        // ADD stalled in E3 for three cycles
        run_instr(16'h2042, 1'b0, 1'b0, 1'b0, 3, -1);

        // LDA aborted by reset between edges while in E3
        run_instr(16'h1ABC, 1'b0, 1'b0, 1'b0, -1, 3);
        #2;
        RESET = 1'b0;
        #1;
        chk("reset_mid_lda", 3'd0, 15'h0000, 1'b0);
        go_edge();
        chk("reset_held", 3'd0, 15'h0000, 1'b0);
        RESET = 1'b1;
        #1;
        chk("idle_after_abort", 3'd0, 15'h0000, 1'b0);
        go_edge();

        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [11:0] operand;
            op      = 4'($urandom_range(0, 14));
            operand = 12'($urandom);
            run_instr({op, operand}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b1, -1, -1);
        end

        run_instr(16'hF000, 1'b0, 1'b0, 1'b0, -1, -1);
        for (int k = 0; k < 20; k++) begin
            RUN = 1'($urandom_range(0, 1));
            #1;
            chk("halt_absorbing", 3'd7, 15'h0000, 1'b1);
            go_edge();
        end
        RESET = 1'b0;
        #1;
        chk("halt_async_reset", 3'd0, 15'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
